keypad_scanner: RTL

- Upstream front end of the calculator: scans a 4x4 active-low key matrix, debounces it and produces the 4-bit `inkey` code that the calculator consumes.
- Each debounced press drives the key code. Each debounced release drives the idle code 4'b1101, so the calculator's change-triggered input sees every press, including repeats of the same key.
- Key codes: digits 0-9 = 4'b0000-4'b1001, + = 4'b1100, = = 4'b1110, C = 4'b1111, idle = 4'b1101.

---
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column rotation, 2-flop row synchronizer,
// per-frame single/multi key detection and press/release debounce FSM.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] inkey,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [3:0] IDLE_CODE = 4'b1101;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      cand_reg, cand_next;
    logic [3:0]      inkey_reg, inkey_next;
    logic            valid_reg, valid_next;

    logic [3:0]      sync1_reg, sync2_reg;
    logic [DW-1:0]   div_reg;
    logic [3:0]      col_reg;
    logic [1:0]      col_idx_reg;
    logic [1:0]      acc_cnt_reg;
    logic [3:0]      acc_code_reg;

    logic [4:0]      entry [4];
    logic [3:0]      hit;
    logic [1:0]      col_cnt, tot_cnt;
    logic [3:0]      col_code, frame_code;
    logic [2:0]      sum_cnt;
    logic            sample, frame_end;

    // {mapped, code} for the key at row r / column c.
    function automatic logic [4:0] key_at(input logic [1:0] c, input logic [1:0] r);
        case ({r, c})
            4'b00_00: key_at = 5'b1_0001;
            4'b00_01: key_at = 5'b1_0010;
            4'b00_10: key_at = 5'b1_0011;
            4'b00_11: key_at = 5'b1_1100;
            4'b01_00: key_at = 5'b1_0100;
            4'b01_01: key_at = 5'b1_0101;
            4'b01_10: key_at = 5'b1_0110;
            4'b10_00: key_at = 5'b1_0111;
            4'b10_01: key_at = 5'b1_1000;
            4'b10_10: key_at = 5'b1_1001;
            4'b10_11: key_at = 5'b1_1110;
            4'b11_00: key_at = 5'b1_1111;
            4'b11_01: key_at = 5'b1_0000;
            default:  key_at = 5'b0_0000;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign entry[gi] = key_at(col_idx_reg, 2'(gi));
            assign hit[gi]   = ~sync2_reg[gi] & entry[gi][4];
        end
    endgenerate

    assign sample    = (div_reg == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx_reg == 2'd3);

    // Key count saturates at 2: only none/one/many matters.
    always_comb begin
        col_cnt  = 2'd0;
        col_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (hit[r]) begin
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
                col_code = entry[r][3:0];
            end
        end
        sum_cnt    = {1'b0, acc_cnt_reg} + {1'b0, col_cnt};
        tot_cnt    = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        frame_code = (col_cnt != 2'd0) ? col_code : acc_code_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg    <= 4'b1111;
            sync2_reg    <= 4'b1111;
            div_reg      <= '0;
            col_reg      <= 4'b1110;
            col_idx_reg  <= 2'd0;
            acc_cnt_reg  <= 2'd0;
            acc_code_reg <= 4'd0;
        end else begin
            sync1_reg <= row_in;
            sync2_reg <= sync1_reg;
            if (sample) begin
                div_reg     <= '0;
                col_reg     <= {col_reg[2:0], col_reg[3]};
                col_idx_reg <= col_idx_reg + 2'd1;
                if (frame_end) begin
                    acc_cnt_reg  <= 2'd0;
                    acc_code_reg <= 4'd0;
                end else begin
                    acc_cnt_reg  <= tot_cnt;
                    acc_code_reg <= frame_code;
                end
            end else begin
                div_reg <= div_reg + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cand_reg  <= 4'd0;
            inkey_reg <= IDLE_CODE;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            inkey_reg <= inkey_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        inkey_next = inkey_reg;
        valid_next = 1'b0;
        if (frame_end) begin
            case (state_reg)
                IDLE: begin
                    if (tot_cnt == 2'd1) begin
                        if (DEBOUNCE == 1) begin
                            inkey_next = frame_code;
                            valid_next = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            cand_next  = frame_code;
                            cnt_next   = CW'(1);
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (tot_cnt == 2'd1 && frame_code == cand_reg) begin
                        if (cnt_reg + CW'(1) == CW'(DEBOUNCE)) begin
                            inkey_next = cand_reg;
                            valid_next = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (tot_cnt == 2'd0) begin
                        if (DEBOUNCE == 1) begin
                            inkey_next = IDLE_CODE;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = CW'(1);
                            state_next = REL_DB;
                        end
                    end
                end
                default: begin
                    if (tot_cnt == 2'd0) begin
                        if (cnt_reg + CW'(1) == CW'(DEBOUNCE)) begin
                            inkey_next = IDLE_CODE;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end else begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end
                end
            endcase
        end
    end

    assign col_out   = col_reg;
    assign inkey     = inkey_reg;
    assign key_valid = valid_reg;

endmodule
